axi4lite_slave_dma: RTL
=======================

Name: axi4lite_slave_dma

Overview:
- AXI4-Lite slave front end for the DMA register bank.
- Turns host read/write transactions into the bank's flat memory interface: mem_rd_addr/mem_rd_data on the read side and mem_wr_en/mem_wr_addr/mem_wr_data on the write side.
- Sits directly upstream of the combinational read decoder and the write register file.
- Parks the read address between transactions so that address-decoded side effects (frame-size FIFO pop) fire exactly once per AXI read.

Parameters:
ADDR_WIDTH, 32, AXI address width; mem_rd_addr/mem_wr_addr width.
ADDR_DECODER_WIDTH, 8, number of low address bits the register bank decodes.
PARK_ADDR, 8'hFC, unmapped offset driven on mem_rd_addr whenever no read is in flight.

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
s_awaddr  in  ADDR_WIDTH  write address
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  32  write data
s_wstrb  in  4  write byte strobes
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  write response
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_araddr  in  ADDR_WIDTH  read address
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  32  read data
s_rresp  out  2  read response
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
mem_rd_addr  out  ADDR_WIDTH  to register read decoder
mem_rd_data  in  32  combinational data from decoder
mem_wr_en  out  1  single-cycle write commit
mem_wr_addr  out  ADDR_WIDTH  write address to register file
mem_wr_data  out  32  write data to register file

Behaviour:
- Single clock aclk. Reset is synchronous and active-high on areset.
- Reset values:
  - state=IDLE.
  - All ready/valid outputs 0; s_bresp=0, s_rresp=0, s_rdata=0.
  - mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0.
  - mem_rd_addr=PARK_ADDR zero-extended.
  - last_grant=READ.
- FSM states: IDLE, WR_COLLECT, WR_COMMIT, WR_RESP, RD_ADDR, RD_RESP. Only one transaction is in flight at a time.
- IDLE:
  - s_arready, s_awready and s_wready are combinationally 1 only for the channel(s) granted this cycle.
  - Read only pending → grant read. Write only pending (awvalid or wvalid) → grant write.
  - Both pending → grant the opposite of last_grant (round-robin). No starvation.
- Write path:
  - AW and W are accepted independently and latched.
  - Any handshake in IDLE → WR_COLLECT, unless both complete in the same cycle, which goes straight to WR_COMMIT.
  - WR_COLLECT waits for the missing channel, keeping ready high only on that channel.
  - WR_COMMIT lasts 1 cycle: mem_wr_en=1 with latched addr/data. It is suppressed on error.
  - WR_RESP: s_bvalid=1, held with s_bresp stable until s_bready. Then → IDLE, last_grant=WRITE.
- Read path:
  - AR accepted at cycle N (IDLE).
  - N+1 (RD_ADDR): mem_rd_addr=araddr, and mem_rd_data is captured at the end of the cycle.
  - N+2 (RD_RESP): s_rvalid=1 with the captured s_rdata. Held until s_rready, then → IDLE, last_grant=READ.
  - mem_rd_addr returns to PARK_ADDR in every state except RD_ADDR. This guarantees exactly one decode cycle, so exactly one FIFO pop per read.
- Back-to-back reads: minimum 3 cycles per read when s_rready is tied high.
- Reset mid-transaction: the FSM aborts to IDLE and all valids drop the next edge. No mem_wr_en is issued for a partially collected write.
- Address fields are used unmodified. The bank decodes only [ADDR_DECODER_WIDTH-1:0].

Optional Feature:
- Macro AXI_SLVERR_EN.
- Defined:
  - Unaligned read address (araddr[1:0]≠0) → s_rresp=2'b10 and s_rdata=0. The RD_ADDR cycle still occurs, but mem_rd_addr stays PARK_ADDR, so there is no side effect.
  - Unaligned write address or s_wstrb≠4'hF → mem_wr_en suppressed and s_bresp=2'b10.
- Undefined:
  - Responses are always OKAY (2'b00).
  - araddr[1:0] and awaddr[1:0] are forced to 0.
  - Partial-strobe writes commit as full 32-bit words.

Decomposition:
- Shared package dma_axi_pkg holds:
  - FSM state encoding constants.
  - AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10.
  - The default PARK_ADDR.
- No sub-module. The block is a single FSM plus a latch set.

Test Plan:
- Read FRAME_SIZE_FIFO offset with s_rready=1 → mem_rd_addr equals the offset for exactly 1 cycle (N+1); s_rvalid at N+2 with the captured value; park address on all other cycles.
- AW at cycle 0, W at cycle 3 (data 32'hA5A5_0001, wstrb 4'hF) → mem_wr_en pulses once at cycle 4 with correct addr/data; s_bvalid at 5; s_bresp=0.
- arvalid and awvalid/wvalid asserted together, repeated 4 times → grants alternate W,R,W,R (reset last_grant=READ, so write first); no mem_wr_en overlaps RD_ADDR.
- s_rready held low 10 cycles → s_rvalid and s_rdata stable throughout; mem_rd_addr=PARK_ADDR; no further AR accepted.
- With AXI_SLVERR_EN: write wstrb=4'h3 → no mem_wr_en, s_bresp=2'b10; read araddr=0x06 → s_rresp=2'b10, s_rdata=0. Without the macro: the same write commits, the same read returns offset 0x04 with OKAY.
- areset asserted in WR_COLLECT and in RD_RESP → next edge: all valids 0, state IDLE, no mem_wr_en pulse, mem_rd_addr=PARK_ADDR.

Source files
------------

// File: rtl/axi4lite_slave_dma_pkg.sv
// Shared definitions for the DMA register-bank AXI4-Lite front end:
// FSM state encoding, arbitration memory, AXI response codes and the
// default park offset driven on the read decoder between reads.
package dma_axi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_COLLECT,
      WR_COMMIT,
      WR_RESP,
      RD_ADDR,
      RD_RESP
   } state_t;

   typedef enum logic {
      GRANT_READ,
      GRANT_WRITE
   } grant_t;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   localparam logic [7:0] DEFAULT_PARK_ADDR = 8'hFC;

endpackage

// File: rtl/axi4lite_slave_dma_if.sv
// AXI4-Lite host bus bundle for the DMA register bank. The slave modport
// is used by axi4lite_slave_dma, the master modport by the host side.
interface axi4lite_slave_dma_if #(
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] s_awaddr;
   logic                  s_awvalid;
   logic                  s_awready;
   logic [31:0]           s_wdata;
   logic [3:0]            s_wstrb;
   logic                  s_wvalid;
   logic                  s_wready;
   logic [1:0]            s_bresp;
   logic                  s_bvalid;
   logic                  s_bready;
   logic [ADDR_WIDTH-1:0] s_araddr;
   logic                  s_arvalid;
   logic                  s_arready;
   logic [31:0]           s_rdata;
   logic [1:0]            s_rresp;
   logic                  s_rvalid;
   logic                  s_rready;

   modport slave (
      input  s_awaddr, s_awvalid, output s_awready,
      input  s_wdata, s_wstrb, s_wvalid, output s_wready,
      output s_bresp, s_bvalid, input s_bready,
      input  s_araddr, s_arvalid, output s_arready,
      output s_rdata, s_rresp, s_rvalid, input s_rready
   );

   modport master (
      output s_awaddr, s_awvalid, input s_awready,
      output s_wdata, s_wstrb, s_wvalid, input s_wready,
      input  s_bresp, s_bvalid, output s_bready,
      output s_araddr, s_arvalid, input s_arready,
      input  s_rdata, s_rresp, s_rvalid, output s_rready
   );
endinterface

// File: rtl/axi4lite_slave_dma.sv
// AXI4-Lite slave front end for the DMA register bank. One transaction is
// in flight at a time; reads and writes are arbitrated round-robin. The
// read address is parked on an unmapped offset except for the single
// decode cycle of each read, so read side effects fire exactly once.
// Optional macro AXI_SLVERR_EN: unaligned accesses and partial-strobe
// writes return SLVERR instead of being silently word-aligned.
module axi4lite_slave_dma
   import dma_axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int ADDR_DECODER_WIDTH = 8,
   parameter logic [ADDR_DECODER_WIDTH-1:0] PARK_ADDR = DEFAULT_PARK_ADDR
) (
   input  logic                  aclk,
   input  logic                  areset,
   axi4lite_slave_dma_if.slave   bus,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [31:0]           mem_rd_data,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_wr_addr,
   output logic [31:0]           mem_wr_data
);

   localparam logic [ADDR_WIDTH-1:0] PARK_FULL = ADDR_WIDTH'(PARK_ADDR);

   // Without error reporting the two low address bits are simply dropped.
   function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] a);
`ifdef AXI_SLVERR_EN
      return a;
`else
      return a & ~ADDR_WIDTH'(3);
`endif
   endfunction

   state_t                state;
   grant_t                last_grant;
   logic                  aw_got;
   logic                  w_got;
   logic [ADDR_WIDTH-1:0] awaddr_q;
   logic [31:0]           wdata_q;
   logic                  wr_err_q;
   logic                  rd_err_q;
   logic                  bvalid;
   logic [1:0]            bresp;
   logic                  rvalid;
   logic [1:0]            rresp;
   logic [31:0]           rdata;
   logic                  arready;
   logic                  awready;
   logic                  wready;

   logic                  rd_pend;
   logic                  wr_pend;
   logic                  grant_rd;
   logic                  grant_wr;
   logic                  ar_hs;
   logic                  aw_hs;
   logic                  w_hs;
   logic                  both_done;
   logic [ADDR_WIDTH-1:0] awaddr_nxt;
   logic [31:0]           wdata_nxt;
   logic                  wr_err_nxt;
   logic                  rd_err;

   assign rd_pend  = bus.s_arvalid;
   assign wr_pend  = bus.s_awvalid | bus.s_wvalid;
   // When both sides ask, the side that did not win last time goes first.
   assign grant_rd = rd_pend & (~wr_pend | (last_grant == GRANT_WRITE));
   assign grant_wr = wr_pend & (~rd_pend | (last_grant == GRANT_READ));

   // Ready is offered only to the granted channel(s) in IDLE, and only to
   // the still-missing channel while a write is being collected.
   always_comb begin
      arready = 1'b0;
      awready = 1'b0;
      wready  = 1'b0;
      unique case (state)
         IDLE: begin
            arready = grant_rd;
            awready = grant_wr;
            wready  = grant_wr;
         end
         WR_COLLECT: begin
            awready = ~aw_got;
            wready  = ~w_got;
         end
         default: ;
      endcase
   end

   assign ar_hs     = bus.s_arvalid & arready;
   assign aw_hs     = bus.s_awvalid & awready;
   assign w_hs      = bus.s_wvalid & wready;
   assign both_done = (aw_got | aw_hs) & (w_got | w_hs);

   // Merge a handshake arriving this cycle with what was latched earlier.
   assign awaddr_nxt = aw_hs ? word_addr(bus.s_awaddr) : awaddr_q;
   assign wdata_nxt  = w_hs ? bus.s_wdata : wdata_q;

`ifdef AXI_SLVERR_EN
   logic [3:0] wstrb_q;
   logic [3:0] wstrb_nxt;
   assign wstrb_nxt  = w_hs ? bus.s_wstrb : wstrb_q;
   assign wr_err_nxt = (awaddr_nxt[1:0] != 2'b00) || (wstrb_nxt != 4'hF);
   assign rd_err     = bus.s_araddr[1:0] != 2'b00;
`else
   // Partial strobes commit as full words, so the strobes carry no meaning.
   logic unused_wstrb;
   assign unused_wstrb = ^bus.s_wstrb;
   assign wr_err_nxt   = 1'b0;
   assign rd_err       = 1'b0;
`endif

   assign bus.s_arready = arready;
   assign bus.s_awready = awready;
   assign bus.s_wready  = wready;
   assign bus.s_bvalid  = bvalid;
   assign bus.s_bresp   = bresp;
   assign bus.s_rvalid  = rvalid;
   assign bus.s_rresp   = rresp;
   assign bus.s_rdata   = rdata;

   // Transaction FSM with registered responses and memory-side strobes.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state       <= IDLE;
         last_grant  <= GRANT_READ;
         aw_got      <= 1'b0;
         w_got       <= 1'b0;
         awaddr_q    <= '0;
         wdata_q     <= '0;
         wr_err_q    <= 1'b0;
         rd_err_q    <= 1'b0;
         bvalid      <= 1'b0;
         bresp       <= AXI_RESP_OKAY;
         rvalid      <= 1'b0;
         rresp       <= AXI_RESP_OKAY;
         rdata       <= '0;
         mem_wr_en   <= 1'b0;
         mem_wr_addr <= '0;
         mem_wr_data <= '0;
         mem_rd_addr <= PARK_FULL;
`ifdef AXI_SLVERR_EN
         wstrb_q     <= '0;
`endif
      end else begin
         mem_wr_en   <= 1'b0;
         mem_rd_addr <= PARK_FULL;
         if (aw_hs) begin
            awaddr_q <= word_addr(bus.s_awaddr);
            aw_got   <= 1'b1;
         end
         if (w_hs) begin
            wdata_q <= bus.s_wdata;
            w_got   <= 1'b1;
`ifdef AXI_SLVERR_EN
            wstrb_q <= bus.s_wstrb;
`endif
         end
         unique case (state)
            IDLE: begin
               if (ar_hs) begin
                  rd_err_q <= rd_err;
                  // An erroring read keeps the decoder parked: no side effect.
                  if (!rd_err) mem_rd_addr <= word_addr(bus.s_araddr);
                  state <= RD_ADDR;
               end else if (both_done) begin
                  mem_wr_en   <= ~wr_err_nxt;
                  mem_wr_addr <= awaddr_nxt;
                  mem_wr_data <= wdata_nxt;
                  wr_err_q    <= wr_err_nxt;
                  state       <= WR_COMMIT;
               end else if (aw_hs || w_hs) begin
                  state <= WR_COLLECT;
               end
            end
            WR_COLLECT: begin
               if (both_done) begin
                  mem_wr_en   <= ~wr_err_nxt;
                  mem_wr_addr <= awaddr_nxt;
                  mem_wr_data <= wdata_nxt;
                  wr_err_q    <= wr_err_nxt;
                  state       <= WR_COMMIT;
               end
            end
            WR_COMMIT: begin
               aw_got <= 1'b0;
               w_got  <= 1'b0;
               bvalid <= 1'b1;
               bresp  <= wr_err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
               state  <= WR_RESP;
            end
            WR_RESP: begin
               if (bus.s_bready) begin
                  bvalid     <= 1'b0;
                  last_grant <= GRANT_WRITE;
                  state      <= IDLE;
               end
            end
            RD_ADDR: begin
               rdata  <= rd_err_q ? 32'h0 : mem_rd_data;
               rresp  <= rd_err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
               rvalid <= 1'b1;
               state  <= RD_RESP;
            end
            RD_RESP: begin
               if (bus.s_rready) begin
                  rvalid     <= 1'b0;
                  last_grant <= GRANT_READ;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
